// File: rtl/seq_checker.sv
// Receive-side checker for a modulo-2^DATA_WIDTH up-count stream.
// Acquires lock after a seed plus LOCK_COUNT matches, then flags and counts breaks.
module seq_checker #(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned LOCK_COUNT    = 3,
  parameter int unsigned UNLOCK_COUNT  = 2,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     C,
  input  logic                     R,
  input  logic [DATA_WIDTH-1:0]    D,
  input  logic                     E,
  input  logic                     CLR,
  output logic                     LOCK,
  output logic                     ERR,
  output logic [ERR_CNT_WIDTH-1:0] ERR_CNT,
  output logic [DATA_WIDTH-1:0]    EXP
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned SW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [DATA_WIDTH-1:0]    DATA_ONE  = DATA_WIDTH'(1);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE   = ERR_CNT_WIDTH'(1);
  localparam logic [MW-1:0]            MATCH_ONE = MW'(1);
  localparam logic [MW-1:0]            MATCH_END = MW'(LOCK_COUNT - 1);
  localparam logic [SW-1:0]            MISS_ONE  = SW'(1);
  localparam logic [SW-1:0]            MISS_END  = SW'(UNLOCK_COUNT - 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    exp_q, exp_d;
  logic [MW-1:0]            match_q, match_d;
  logic [SW-1:0]            miss_q, miss_d;
  logic                     lock_q, lock_d;
  logic                     err_q, err_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     count_err;

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q <= UNLOCKED;
      exp_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    match_d   = match_q;
    miss_d    = miss_q;
    lock_d    = lock_q;
    err_d     = 1'b0;
    count_err = 1'b0;
    if (E) begin
      unique case (state_q)
        UNLOCKED: begin
          exp_d   = D + DATA_ONE;
          match_d = '0;
          state_d = LOCKING;
        end
        LOCKING: begin
          if (D == exp_q) begin
            exp_d   = exp_q + DATA_ONE;
            match_d = match_q + MATCH_ONE;
            if (match_q == MATCH_END) begin
              state_d = LOCKED;
              lock_d  = 1'b1;
              miss_d  = '0;
            end
          end else begin
            exp_d   = D + DATA_ONE;
            match_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: expectation advances on mismatches too, no reseed while locked.
          exp_d = exp_q + DATA_ONE;
          if (D == exp_q) begin
            miss_d = '0;
          end else begin
            err_d     = 1'b1;
            count_err = 1'b1;
            if (miss_q == MISS_END) begin
              state_d = UNLOCKED;
              lock_d  = 1'b0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MISS_ONE;
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  // A clear coinciding with a counted error leaves that one error on the total.
  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = count_err ? CNT_ONE : '0;
    end else if (count_err && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  assign LOCK    = lock_q;
  assign ERR     = err_q;
  assign ERR_CNT = cnt_q;
  assign EXP     = exp_q;

endmodule

// File: tb/tb_seq_checker.sv
// Randomized bench for seq_checker with directed scenarios and a behavioural model.
module tb_seq_checker;

  localparam int DW    = 4;
  localparam int LC    = 3;
  localparam int UC    = 2;
  localparam int CW    = 2;
  localparam int NMOD  = 1 << DW;
  localparam int CMAX  = (1 << CW) - 1;

  logic          C = 1'b0;
  logic          R = 1'b1;
  logic [DW-1:0] D = '0;
  logic          E = 1'b0;
  logic          CLR = 1'b0;
  logic          LOCK;
  logic          ERR;
  logic [CW-1:0] ERR_CNT;
  logic [DW-1:0] EXP;

  seq_checker #(
    .DATA_WIDTH   (DW),
    .LOCK_COUNT   (LC),
    .UNLOCK_COUNT (UC),
    .ERR_CNT_WIDTH(CW)
  ) dut (
    .C      (C),
    .R      (R),
    .D      (D),
    .E      (E),
    .CLR    (CLR),
    .LOCK   (LOCK),
    .ERR    (ERR),
    .ERR_CNT(ERR_CNT),
    .EXP    (EXP)
  );

  always #5 C = ~C;

  int total = 0;
  int bad   = 0;
  int err_pulses = 0;

  // Reference: seeded/locked flags, run length of matches, streak of misses.
  bit m_seeded = 0;
  bit m_lock   = 0;
  bit m_err    = 0;
  int m_exp    = 0;
  int m_run    = 0;
  int m_miss   = 0;
  int m_cnt    = 0;

  task automatic check_val(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_seeded = 0; m_lock = 0; m_err = 0;
    m_exp = 0; m_run = 0; m_miss = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input int d, input bit e, input bit clr);
    bit counted;
    counted = 0;
    m_err = 0;
    if (e) begin
      if (!m_seeded) begin
        m_exp = (d + 1) % NMOD;
        m_run = 0;
        m_seeded = 1;
      end else if (!m_lock) begin
        if (d == m_exp) begin
          m_exp = (m_exp + 1) % NMOD;
          m_run++;
          if (m_run == LC) begin
            m_lock = 1;
            m_miss = 0;
          end
        end else begin
          m_exp = (d + 1) % NMOD;
          m_run = 0;
        end
      end else begin
        if (d == m_exp) begin
          m_miss = 0;
        end else begin
          m_err = 1;
          counted = 1;
          m_miss++;
          if (m_miss == UC) begin
            m_lock = 0;
            m_seeded = 0;
            m_miss = 0;
          end
        end
        m_exp = (m_exp + 1) % NMOD;
      end
    end
    if (clr) m_cnt = counted ? 1 : 0;
    else if (counted && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".lock"}, int'(LOCK), int'(m_lock));
    check_val({tag, ".err"}, int'(ERR), int'(m_err));
    check_val({tag, ".cnt"}, int'(ERR_CNT), m_cnt);
    check_val({tag, ".exp"}, int'(EXP), m_exp);
  endtask

  task automatic step(input int d, input bit e, input bit clr);
    logic [31:0] dv;
    dv = d;
    @(negedge C);
    D = dv[DW-1:0];
    E = e;
    CLR = clr;
    @(posedge C);
    model_edge(d, e, clr);
    #1;
    if (ERR) err_pulses++;
    check_outputs("step");
  endtask

  // Asynchronous pulse placed between clock edges; outputs must clear before the next edge.
  task automatic pulse_reset();
    E = 0;
    CLR = 0;
    #2 R = 1;
    #2;
    check_val("rst.lock", int'(LOCK), 0);
    check_val("rst.err", int'(ERR), 0);
    check_val("rst.cnt", int'(ERR_CNT), 0);
    check_val("rst.exp", int'(EXP), 0);
    R = 0;
    model_reset();
  endtask

  task automatic feed_to(input int target);
    for (int i = 0; i < NMOD + 1 && m_exp != target; i++) step(m_exp, 1, 0);
  endtask

  int saved_exp;
  bit saved_lock;
  int pulses_before;

  initial begin
    #3;
    check_val("init.lock", int'(LOCK), 0);
    check_val("init.err", int'(ERR), 0);
    check_val("init.cnt", int'(ERR_CNT), 0);
    check_val("init.exp", int'(EXP), 0);
    @(negedge C);
    R = 0;

    // Acquisition from reset and wrap.
    for (int v = 0; v < 4; v++) step(v, 1, 0);
    check_val("acq.lock", int'(LOCK), 1);
    check_val("acq.exp", int'(EXP), 4);
    for (int v = 4; v < 18; v++) step(v % NMOD, 1, 0);
    check_val("wrap.pulses", err_pulses, 0);
    check_val("wrap.cnt", int'(ERR_CNT), 0);

    // Single glitch.
    feed_to(5);
    pulses_before = err_pulses;
    step(5, 1, 0); step(6, 1, 0); step(9, 1, 0);
    check_val("glitch.err", int'(ERR), 1);
    step(8, 1, 0); step(9, 1, 0);
    check_val("glitch.pulses", err_pulses - pulses_before, 1);
    check_val("glitch.cnt", int'(ERR_CNT), 1);
    check_val("glitch.lock", int'(LOCK), 1);

    // Loss of lock and relock.
    feed_to(5);
    step(5, 1, 0); step(6, 1, 0); step(0, 1, 0); step(0, 1, 0);
    check_val("loss.lock", int'(LOCK), 0);
    check_val("loss.cnt", int'(ERR_CNT), 3);
    step(2, 1, 0);
    check_val("loss.reseed", int'(EXP), 3);
    step(3, 1, 0); step(4, 1, 0); step(5, 1, 0);
    check_val("relock.lock", int'(LOCK), 1);

    // Gating: D wanders while E=0.
    for (int k = 0; k < 4; k++) begin
      saved_exp = int'(EXP);
      saved_lock = LOCK;
      step(int'($urandom_range(0, NMOD - 1)), 0, 0);
      check_val("gate.exp", int'(EXP), saved_exp);
      check_val("gate.lock", int'(LOCK), int'(saved_lock));
      step(m_exp, 1, 0);
    end

    // Saturation and clear.
    step(m_exp, 1, 1);
    check_val("clr.cnt", int'(ERR_CNT), 0);
    pulses_before = err_pulses;
    for (int g = 0; g < 5; g++) begin
      step((m_exp + 3) % NMOD, 1, 0);
      step(m_exp, 1, 0);
    end
    check_val("sat.pulses", err_pulses - pulses_before, 5);
    check_val("sat.cnt", int'(ERR_CNT), 3);
    step((m_exp + 3) % NMOD, 1, 1);
    check_val("clr_err.cnt", int'(ERR_CNT), 1);
    step(m_exp, 1, 1);
    check_val("clr_only.cnt", int'(ERR_CNT), 0);
    check_val("clr_only.lock", int'(LOCK), 1);

    // Reset mid-stream, then 7,8,9,10.
    pulse_reset();
    step(7, 1, 0); step(8, 1, 0); step(9, 1, 0); step(10, 1, 0);
    check_val("rst_relock.lock", int'(LOCK), 1);
    check_val("rst_relock.exp", int'(EXP), 11);

    // Randomized soak.
    for (int n = 0; n < 3000; n++) begin
      int d;
      bit e;
      bit clr;
      if ($urandom_range(0, 199) == 0) pulse_reset();
      e = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      d = ($urandom_range(0, 99) < 85) ? m_exp : int'($urandom_range(0, NMOD - 1));
      step(d, e, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
# seq_checker

Receive-side checker for the incrementing data stream a registered source produces: the sink end of the count-up pattern the register stimulus drives. It samples a data bus every qualified clock and locks onto a modulo-2^DATA_WIDTH up-count. Once locked, it flags every sample that breaks the count and keeps a saturating error total. It sits after a register or link under test, in simulation or in hardware bring-up.

## Interface
- DATA_WIDTH, 4: width of checked data.
- LOCK_COUNT, 3: consecutive matches after seeding required to declare lock (>=1).
- UNLOCK_COUNT, 2: consecutive mismatches while locked that drop lock (>=1).
- ERR_CNT_WIDTH, 8: width of error counter.
- C  input  1  clock, rising edge.
- R  input  1  reset, asynchronous, active-high.
- D  input  DATA_WIDTH  observed data sample.
- E  input  1  sample valid; D is checked only on edges where E=1.
- CLR  input  1  synchronous clear of ERR_CNT.
- LOCK  output  1  checker locked to the count.
- ERR  output  1  one-cycle pulse per mismatching sample while locked.
- ERR_CNT  output  ERR_CNT_WIDTH  saturating mismatch total.
- EXP  output  DATA_WIDTH  value expected on the next valid sample.

## Operation
- Reset (R=1, asynchronous): state UNLOCKED; LOCK=0, ERR=0, ERR_CNT=0, EXP=0; match and miss counters 0. All outputs are registered.
- E=0: state, EXP, and all counters hold; ERR=0. CLR still acts.
- UNLOCKED: on a valid sample, EXP<=D+1 (mod 2^W), match<=0, go to LOCKING.
- LOCKING:
  - D==EXP: EXP<=EXP+1, match<=match+1. When match reaches LOCK_COUNT (the LOCK_COUNT-th match), go to LOCKED, LOCK<=1, miss<=0.
  - D!=EXP: reseed with EXP<=D+1, match<=0, stay in LOCKING. No ERR, no count.
- LOCKED:
  - D==EXP: EXP<=EXP+1, miss<=0.
  - D!=EXP: ERR<=1, ERR_CNT<=ERR_CNT+1 (saturating at all-ones), EXP<=EXP+1 (flywheel; no reseed), miss<=miss+1. When miss reaches UNLOCK_COUNT, go to UNLOCKED, LOCK<=0, miss<=0.
- Arithmetic:
  - EXP wraps from 2^W-1 to 0 with no error.
  - Comparison uses all DATA_WIDTH bits.
- CLR:
  - ERR_CNT<=0, unless an error is counted on the same edge, in which case ERR_CNT<=1.
  - CLR does not affect state, LOCK, or EXP.
- Reset mid-operation: takes effect immediately without waiting for an edge. The first edge after R falls is treated as a fresh UNLOCKED sample.

## Timing
- All decisions are taken on the rising edge of C that samples D with E=1. Outputs reflect that decision right after the same edge, so latency is one edge.
- ERR is high for exactly one cycle per mismatching sample. Back-to-back mismatches give a continuous high with one count per edge.
- Lock from reset with a clean stream: 1 seeding sample plus LOCK_COUNT matching samples, i.e. LOCK rises after valid edge LOCK_COUNT+1.
- Unlock: LOCK falls after the edge sampling the UNLOCK_COUNT-th consecutive mismatch. ERR is pulsed for that sample too.
- After unlock, the next valid sample reseeds. Relock needs another LOCK_COUNT matches.

## Test plan
- Reset during lock: R pulsed high for 2 ns mid-stream -> LOCK, ERR, ERR_CNT, and EXP read 0 before the next clock edge. After R falls, stream 7,8,9,10 -> LOCK=1 after the edge sampling 10, EXP=11.
- Acquisition and wrap (defaults): E=1 from reset with D=0,1,2,3,… -> LOCK=1 after the 4th edge with EXP=4. Continuing through 14,15,0,1 -> ERR never asserts, ERR_CNT=0.
- Single glitch: locked stream 5,6,9,8,9 -> one ERR pulse after the edge sampling 9, ERR_CNT=1, LOCK stays 1, sample 8 matches, miss returns to 0.
- Loss of lock: locked stream 5,6,0,0,2,3,4,5 -> ERR high for two cycles, ERR_CNT=2, LOCK=0 after the second 0. The 2 reseeds (EXP=3). LOCK=1 again after the edge sampling 5.
- Gating: E toggled 1,0,1,0 with D changing randomly while E=0 -> no ERR, EXP and state unchanged across E=0 cycles.
- Saturation and clear (ERR_CNT_WIDTH=2): 5 isolated glitches while locked -> ERR_CNT stops at 3 and ERR still pulses 5 times. CLR on the same edge as a 6th glitch -> ERR_CNT=1. CLR alone -> ERR_CNT=0, LOCK unchanged.
